sprite_line_scanner: RTL and testbench

- Read-side consumer of the sprite attribute RAM.
- Once per video line it walks all 64 sprite slots through the RAM's asynchronous second read port (spr_sel in, attribute fields out) and decides which sprites intersect the requested line.
- For each hit it emits one render entry (X, tile index, tile row, flags) over a valid/ready handshake to the line renderer.
- Sits between the attribute RAM and the sprite line-buffer renderer in the video pipeline.

---
 rtl/sprite_line_scanner_pkg.sv | 23 ++
 rtl/sprite_line_scanner_hit_calc.sv | 26 ++
 rtl/sprite_line_scanner.sv | 176 +++++++++++++++++
 tb/tb_sprite_line_scanner.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_scanner_pkg.sv
// Shared video definitions for the sprite line scanner: attribute widths,
// the render-entry record and the scanner FSM states.
package sprite_line_scanner_pkg;
  localparam int SPR_SLOTS = 64;
  localparam int SLOT_W    = 6;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int IDX_W     = 10;
  localparam int PAL_W     = 2;
  localparam int ROW_W     = 3;
  localparam int CNT_W     = 6;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] row;
    logic [PAL_W-1:0] palette;
    logic             prio;
    logic             hflip;
  } ent_t;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;
endpackage

// File: rtl/sprite_line_scanner_hit_calc.sv
// Combinational vertical hit test for one sprite against one line: row within
// the 8x8 tile (after vflip) and tile index bumped for the lower half of 16-tall sprites.
module sprite_hit_calc
  import sprite_line_scanner_pkg::*;
(
  input  logic [Y_W-1:0]   i_line,
  input  logic [Y_W-1:0]   i_y,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_h16,
  input  logic             i_vflip,
  output logic             o_hit,
  output logic [ROW_W-1:0] o_row,
  output logic [IDX_W-1:0] o_idx
);
  logic [Y_W-1:0] w_dy;
  logic [3:0]     w_hmax;
  logic [3:0]     w_r;

  // 8-bit subtraction wraps, so sprites near the bottom reach into the top lines
  assign w_dy   = i_line - i_y;
  assign w_hmax = i_h16 ? 4'd15 : 4'd7;
  assign o_hit  = (w_dy <= {4'b0, w_hmax});
  assign w_r    = i_vflip ? (w_hmax - w_dy[3:0]) : w_dy[3:0];
  assign o_row  = w_r[2:0];
  assign o_idx  = i_idx + {{(IDX_W-1){1'b0}}, i_h16 & w_r[3]};
endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line sprite scanner: walks all attribute slots through a 2-stage pipeline
// and emits one render entry per hit over a valid/ready handshake.
module sprite_line_scanner
  import sprite_line_scanner_pkg::*;
#(
  parameter int MAX_PER_LINE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [Y_W-1:0]    line_num,
  output logic [SLOT_W-1:0] spr_sel,
  input  logic [X_W-1:0]    spr_x,
  input  logic [Y_W-1:0]    spr_y,
  input  logic [IDX_W-1:0]  spr_idx,
  input  logic              spr_priority,
  input  logic [PAL_W-1:0]  spr_palette,
  input  logic              spr_h16,
  input  logic              spr_vflip,
  input  logic              spr_hflip,
  output logic              ent_valid,
  input  logic              ent_ready,
  output logic [X_W-1:0]    ent_x,
  output logic [IDX_W-1:0]  ent_idx,
  output logic [ROW_W-1:0]  ent_row,
  output logic [PAL_W-1:0]  ent_palette,
  output logic              ent_priority,
  output logic              ent_hflip,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPR_SLOTS - 1);

  state_t             r_state, w_state_nxt;
  logic [Y_W-1:0]     r_line;
  logic [SLOT_W-1:0]  r_slot;
  logic               r_issue;

  logic               r_s0_vld, r_s0_last;
  logic [X_W-1:0]     r_s0_x;
  logic [Y_W-1:0]     r_s0_y;
  logic [IDX_W-1:0]   r_s0_idx;
  logic [PAL_W-1:0]   r_s0_pal;
  logic               r_s0_prio, r_s0_h16, r_s0_vflip, r_s0_hflip;

  ent_t               r_ent;
  logic               r_vld;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic               r_done;

  logic               w_hit, w_stall, w_room, w_load, w_last_eval, w_fin, w_busy;
  logic [ROW_W-1:0]   w_row;
  logic [IDX_W-1:0]   w_idx;

  sprite_hit_calc u_hit (
    .i_line  (r_line),
    .i_y     (r_s0_y),
    .i_idx   (r_s0_idx),
    .i_h16   (r_s0_h16),
    .i_vflip (r_s0_vflip),
    .o_hit   (w_hit),
    .o_row   (w_row),
    .o_idx   (w_idx)
  );

  // A hit facing an unaccepted entry freezes stage 1, stage 0 and the slot counter
  assign w_stall     = r_s0_vld & w_hit & r_vld & ~ent_ready;
  assign w_room      = (r_count < CNT_W'(MAX_PER_LINE));
  assign w_load      = r_s0_vld & w_hit & ~w_stall & w_room;
  assign w_last_eval = r_s0_vld & r_s0_last & ~w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (line_start) w_state_nxt = SCAN;
    else begin
      case (r_state)
        SCAN:    if (w_last_eval) w_state_nxt = FLUSH;
        FLUSH:   if (!r_vld || ent_ready) w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != IDLE);
    w_fin  = (r_state == FLUSH) & ~line_start & (~r_vld | ent_ready);
  end

  // Slot counter and stage 0 attribute capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line     <= '0;
      r_slot     <= '0;
      r_issue    <= 1'b0;
      r_s0_vld   <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_x     <= '0;
      r_s0_y     <= '0;
      r_s0_idx   <= '0;
      r_s0_pal   <= '0;
      r_s0_prio  <= 1'b0;
      r_s0_h16   <= 1'b0;
      r_s0_vflip <= 1'b0;
      r_s0_hflip <= 1'b0;
    end else if (line_start) begin
      r_line   <= line_num;
      r_slot   <= '0;
      r_issue  <= 1'b1;
      r_s0_vld <= 1'b0;
    end else if (!w_stall) begin
      r_s0_vld   <= r_issue;
      r_s0_last  <= (r_slot == LAST_SLOT);
      r_s0_x     <= spr_x;
      r_s0_y     <= spr_y;
      r_s0_idx   <= spr_idx;
      r_s0_pal   <= spr_palette;
      r_s0_prio  <= spr_priority;
      r_s0_h16   <= spr_h16;
      r_s0_vflip <= spr_vflip;
      r_s0_hflip <= spr_hflip;
      if (r_issue) begin
        if (r_slot == LAST_SLOT) r_issue <= 1'b0;
        else                     r_slot  <= r_slot + 1'b1;
      end
    end
  end

  // Output entry register, per-line count and overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ent   <= '0;
      r_vld   <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (line_start) begin
        r_vld   <= 1'b0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_load) begin
          r_ent   <= '{x: r_s0_x, idx: w_idx, row: w_row, palette: r_s0_pal,
                       prio: r_s0_prio, hflip: r_s0_hflip};
          r_vld   <= 1'b1;
          r_count <= r_count + 1'b1;
        end else if (ent_ready) begin
          r_vld <= 1'b0;
        end
        if (r_s0_vld && w_hit && !w_stall && !w_room) r_ovf <= 1'b1;
      end
    end
  end

  assign spr_sel      = r_slot;
  assign ent_valid    = r_vld;
  assign ent_x        = r_ent.x;
  assign ent_idx      = r_ent.idx;
  assign ent_row      = r_ent.row;
  assign ent_palette  = r_ent.palette;
  assign ent_priority = r_ent.prio;
  assign ent_hflip    = r_ent.hflip;
  assign busy         = w_busy;
  assign done         = r_done;
  assign count        = r_count;
  assign overflow     = r_ovf;
endmodule

// File: tb/tb_sprite_line_scanner.sv
// Directed bench for sprite_line_scanner: a behavioural attribute RAM, a queue of
// hand-computed entries, and a monitor that pops and compares on every transfer.
module tb_sprite_line_scanner;
  import sprite_line_scanner_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  line_num;
  logic [5:0]  spr_sel;
  logic [8:0]  spr_x;
  logic [7:0]  spr_y;
  logic [9:0]  spr_idx;
  logic        spr_priority;
  logic [1:0]  spr_palette;
  logic        spr_h16, spr_vflip, spr_hflip;
  logic        ent_valid, ent_ready;
  logic [8:0]  ent_x;
  logic [9:0]  ent_idx;
  logic [2:0]  ent_row;
  logic [1:0]  ent_palette;
  logic        ent_priority, ent_hflip;
  logic        busy, done, overflow;
  logic [5:0]  count;

  logic [8:0] ram_x   [SPR_SLOTS];
  logic [7:0] ram_y   [SPR_SLOTS];
  logic [9:0] ram_idx [SPR_SLOTS];
  logic [1:0] ram_pal [SPR_SLOTS];
  logic       ram_pri [SPR_SLOTS];
  logic       ram_h16 [SPR_SLOTS];
  logic       ram_vf  [SPR_SLOTS];
  logic       ram_hf  [SPR_SLOTS];

  assign spr_x        = ram_x[spr_sel];
  assign spr_y        = ram_y[spr_sel];
  assign spr_idx      = ram_idx[spr_sel];
  assign spr_palette  = ram_pal[spr_sel];
  assign spr_priority = ram_pri[spr_sel];
  assign spr_h16      = ram_h16[spr_sel];
  assign spr_vflip    = ram_vf[spr_sel];
  assign spr_hflip    = ram_hf[spr_sel];

  sprite_line_scanner #(.MAX_PER_LINE(32)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
    .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
    .spr_priority(spr_priority), .spr_palette(spr_palette), .spr_h16(spr_h16),
    .spr_vflip(spr_vflip), .spr_hflip(spr_hflip), .ent_valid(ent_valid),
    .ent_ready(ent_ready), .ent_x(ent_x), .ent_idx(ent_idx), .ent_row(ent_row),
    .ent_palette(ent_palette), .ent_priority(ent_priority), .ent_hflip(ent_hflip),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  int   checks = 0, failures = 0;
  int   cyc = 0, t_start = 0;
  int   done_cnt = 0, done_cyc = 0;
  ent_t sb[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: done bookkeeping, stability while stalled, scoreboard pops on transfer
  initial begin
    ent_t got, exp, held;
    logic held_v;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      got = '{x: ent_x, idx: ent_idx, row: ent_row, palette: ent_palette,
              prio: ent_priority, hflip: ent_hflip};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checks++;
        if (sb.size() != 0) begin
          failures++;
          $display("FAIL done_before_drain: pending=%0d required=0", sb.size());
        end
      end
      if (ent_valid && held_v) begin
        checks++;
        if (got != held) begin
          failures++;
          $display("FAIL ent_stable: got=%h required=%h", got, held);
        end
      end
      if (ent_valid && ent_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_entry: got=%h required=none", got);
        end else begin
          exp = sb.pop_front();
          if (got != exp) begin
            failures++;
            $display("FAIL entry: got x=%0d idx=%h row=%0d pal=%0d pri=%0d hf=%0d required x=%0d idx=%h row=%0d pal=%0d pri=%0d hf=%0d",
                     got.x, got.idx, got.row, got.palette, got.prio, got.hflip,
                     exp.x, exp.idx, exp.row, exp.palette, exp.prio, exp.hflip);
          end
        end
      end
      held_v = ent_valid && !ent_ready;
      held   = got;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d required=%0d", nm, got, exp);
    end
  endtask

  function automatic ent_t mk(input int x, input int idx, input int row,
                              input int pal, input int pri, input int hf);
    mk = '{x: 9'(x), idx: 10'(idx), row: 3'(row), palette: 2'(pal),
           prio: 1'(pri), hflip: 1'(hf)};
  endfunction

  task automatic set_slot(input int s, input int x, input int y, input int idx, input int pal,
                          input int pri, input int h16, input int vf, input int hf);
    ram_x[s] = 9'(x);     ram_y[s] = 8'(y);     ram_idx[s] = 10'(idx);
    ram_pal[s] = 2'(pal); ram_pri[s] = 1'(pri); ram_h16[s] = 1'(h16);
    ram_vf[s] = 1'(vf);   ram_hf[s] = 1'(hf);
  endtask

  // y=200, 8 tall: misses every line used below
  task automatic clear_ram();
    for (int s = 0; s < SPR_SLOTS; s++) set_slot(s, 0, 200, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_line(input int n);
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 8'(n);
    @(posedge clk);
    #1;
    t_start    = cyc;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit tog, input string nm);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (tog) ent_ready = ~ent_ready;
    end
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL %s_timeout: got=no_done required=done within %0d cycles", nm, max_cyc);
    end
  endtask

  task automatic fill_all_hit();
    for (int s = 0; s < SPR_SLOTS; s++)
      set_slot(s, s + 10, 50 - (s % 8), s * 3, s % 4, s % 2, 0, 0, (s / 2) % 2);
  endtask

  task automatic push_first32();
    for (int s = 0; s < 32; s++)
      sb.push_back(mk(s + 10, s * 3, s % 8, s % 4, s % 2, (s / 2) % 2));
  endtask

  initial begin
    int d0;
    reset = 1'b1; line_start = 1'b0; line_num = '0; ent_ready = 1'b0;
    clear_ram();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_spr_sel", int'(spr_sel), 0);
    chk("rst_ent_valid", int'(ent_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_ent_idx", int'(ent_idx), 0);
    reset = 1'b0;

    // single hit, 8 tall
    set_slot(5, 123, 100, 'h040, 2, 1, 0, 0, 1);
    sb.push_back(mk(123, 'h040, 3, 2, 1, 1));
    ent_ready = 1'b1;
    start_line(103);
    wait_done(200, 0, "t1");
    chk("t1_done_latency", done_cyc - t_start, 66);
    chk("t1_count", int'(count), 1);
    chk("t1_overflow", int'(overflow), 0);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_sb_empty", sb.size(), 0);

    // 16 tall, vflip, upper and lower halves
    clear_ram();
    set_slot(0, 7, 10, 'h200, 1, 0, 1, 1, 0);
    sb.push_back(mk(7, 'h201, 5, 1, 0, 0));
    start_line(12);
    wait_done(200, 0, "t2");
    chk("t2_count", int'(count), 1);
    sb.push_back(mk(7, 'h200, 5, 1, 0, 0));
    start_line(20);
    wait_done(200, 0, "t3");
    chk("t3_count", int'(count), 1);

    // vertical wrap
    clear_ram();
    set_slot(7, 300, 250, 'h123, 3, 0, 1, 0, 0);
    sb.push_back(mk(300, 'h124, 0, 3, 0, 0));
    start_line(2);
    wait_done(200, 0, "t4a");
    chk("t4a_count", int'(count), 1);
    set_slot(7, 300, 250, 'h123, 3, 0, 0, 0, 0);
    start_line(2);
    wait_done(200, 0, "t4b");
    chk("t4b_count", int'(count), 0);
    chk("t4b_done_latency", done_cyc - t_start, 66);

    // every slot hits: limit, overflow, ready toggling
    fill_all_hit();
    push_first32();
    start_line(50);
    wait_done(600, 1, "t5");
    chk("t5_count", int'(count), 32);
    chk("t5_overflow", int'(overflow), 1);
    chk("t5_sb_empty", sb.size(), 0);

    // abort while an entry is pending
    ent_ready = 1'b0;
    d0 = done_cnt;
    start_line(50);
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("t6_pending_valid", int'(ent_valid), 1);
    chk("t6_pending_x", int'(ent_x), 10);
    start_line(50);
    chk("t6_valid_dropped", int'(ent_valid), 0);
    chk("t6_restart_slot", int'(spr_sel), 0);
    chk("t6_busy", int'(busy), 1);
    chk("t6_count_cleared", int'(count), 0);
    sb.delete();
    push_first32();
    ent_ready = 1'b1;
    wait_done(400, 0, "t6");
    chk("t6_single_done", done_cnt - d0, 1);
    chk("t6_count", int'(count), 32);
    chk("t6_overflow", int'(overflow), 1);

    // async reset mid-scan
    d0 = done_cnt;
    push_first32();
    start_line(50);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t7_ent_valid", int'(ent_valid), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_count", int'(count), 0);
    chk("t7_spr_sel", int'(spr_sel), 0);
    chk("t7_ent_x", int'(ent_x), 0);
    chk("t7_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    repeat (80) @(posedge clk);
    @(negedge clk);
    chk("t7_no_done", done_cnt - d0, 0);
    chk("t7_idle_valid", int'(ent_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
